ex_mem_stage: RTL and testbench

- Pipeline register between the 64-bit ALU (execute) and the memory/PC-select stage.
- Captures the ALU result F, the 4-bit status {V,C,Z,N}, store data, destination register and control bits each cycle.
- Owns the architectural NZCV flag register; evaluates CBZ, CBNZ and B.cond and registers the branch decision for the PC logic.
- Supports stall (hold) and flush (bubble insertion).

---
 rtl/ex_mem_stage_if.sv | 44 ++++
 rtl/ex_mem_stage.sv | 67 ++++++
 tb/tb_ex_mem_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX->MEM bundle; master drives ex_* and reads mem_*, slave (the stage) reads ex_* and drives mem_*
interface ex_mem_stage_if #(
  parameter int DW = 64,
  parameter int RW = 5
);
  logic ex_valid;
  logic [DW-1:0] ex_F;
  logic [3:0] ex_status;
  logic ex_set_flags;
  logic ex_cbz;
  logic ex_cbnz;
  logic ex_bcond;
  logic ex_uncond;
  logic [3:0] ex_cond;
  logic [DW-1:0] ex_br_target;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic ex_reg_write;
  logic ex_mem_read;
  logic ex_mem_write;
  logic ex_mem_to_reg;
  logic mem_valid;
  logic [DW-1:0] mem_F;
  logic [DW-1:0] mem_store_data;
  logic [DW-1:0] mem_br_target;
  logic [RW-1:0] mem_rd;
  logic mem_reg_write;
  logic mem_mem_read;
  logic mem_mem_write;
  logic mem_mem_to_reg;
  logic mem_br_taken;
  modport master(
    output ex_valid, ex_F, ex_status, ex_set_flags, ex_cbz, ex_cbnz, ex_bcond, ex_uncond, ex_cond,
           ex_br_target, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  mem_valid, mem_F, mem_store_data, mem_br_target, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_mem_to_reg, mem_br_taken
  );
  modport slave(
    input  ex_valid, ex_F, ex_status, ex_set_flags, ex_cbz, ex_cbnz, ex_bcond, ex_uncond, ex_cond,
           ex_br_target, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output mem_valid, mem_F, mem_store_data, mem_br_target, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_mem_to_reg, mem_br_taken
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register owning NZCV flags and branch resolve; ports clock, reset (sync, high), stall, flush, bus (ex_* in, mem_* out), flags; EX_MEM_PERF_CNT_EN adds perf_br_taken/perf_flag_wr
module ex_mem_stage #(
  parameter int DW = 64,
  parameter int RW = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  ex_mem_stage_if.slave bus,
  output logic [3:0] flags
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_br_taken,
  output logic [31:0] perf_flag_wr
`endif
);
  logic n, z, c, v, cond_ok, live, taken, flag_wr;
  logic [7:0] cond_pos;
  always_comb begin
    {v, c, z, n} = flags;
    cond_pos = {1'b1, ~z & (n ~^ v), n ~^ v, c & ~z, v, n, c, z};
    cond_ok = cond_pos[bus.ex_cond[3:1]] ^ (bus.ex_cond[0] & (bus.ex_cond[3:1] != 3'd7));
    live = ~flush & bus.ex_valid;
    taken = live & (bus.ex_uncond | (bus.ex_cbz ? bus.ex_status[1] :
                                     bus.ex_cbnz ? ~bus.ex_status[1] : bus.ex_bcond & cond_ok));
    flag_wr = live & bus.ex_set_flags;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_valid <= 1'b0;
      bus.mem_F <= {DW{1'b0}};
      bus.mem_store_data <= {DW{1'b0}};
      bus.mem_br_target <= {DW{1'b0}};
      bus.mem_rd <= {RW{1'b0}};
      bus.mem_reg_write <= 1'b0;
      bus.mem_mem_read <= 1'b0;
      bus.mem_mem_write <= 1'b0;
      bus.mem_mem_to_reg <= 1'b0;
      bus.mem_br_taken <= 1'b0;
      flags <= 4'b0000;
    end else if (!stall) begin
      bus.mem_valid <= live;
      bus.mem_F <= flush ? {DW{1'b0}} : bus.ex_F;
      bus.mem_store_data <= flush ? {DW{1'b0}} : bus.ex_store_data;
      bus.mem_br_target <= flush ? {DW{1'b0}} : bus.ex_br_target;
      bus.mem_rd <= flush ? {RW{1'b0}} : bus.ex_rd;
      bus.mem_reg_write <= live & bus.ex_reg_write;
      bus.mem_mem_read <= live & bus.ex_mem_read;
      bus.mem_mem_write <= live & bus.ex_mem_write;
      bus.mem_mem_to_reg <= live & bus.ex_mem_to_reg;
      bus.mem_br_taken <= taken;
      if (flag_wr) flags <= bus.ex_status;
    end
  end
`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_br_taken <= 32'd0;
      perf_flag_wr <= 32'd0;
    end else if (!stall) begin
      perf_br_taken <= perf_br_taken + {31'd0, taken};
      perf_flag_wr <= perf_flag_wr + {31'd0, flag_wr};
    end
  end
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed plus random checks of ex_mem_stage against a spec-level reference model
module tb_ex_mem_stage;
  logic clock = 1'b0;
  logic reset, stall, flush;
  logic [3:0] flags;
  int total = 0;
  int bad = 0;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_br_taken, perf_flag_wr;
`endif
  ex_mem_stage_if #(.DW(64), .RW(5)) bus ();
  ex_mem_stage #(.DW(64), .RW(5)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .bus(bus),
    .flags(flags)
`ifdef EX_MEM_PERF_CNT_EN
    ,
    .perf_br_taken(perf_br_taken),
    .perf_flag_wr(perf_flag_wr)
`endif
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic valid;
    logic [63:0] f;
    logic [63:0] sd;
    logic [63:0] bt;
    logic [4:0] rd;
    logic rw, mr, mw, m2r, taken;
    logic [3:0] flags;
    logic [31:0] pbt, pfw;
  } st_t;
  st_t m = '0;
  function automatic logic cond_hold(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cc_, vv;
    nn = f[0];
    zz = f[1];
    cc_ = f[2];
    vv = f[3];
    case (cc)
      4'h0: return zz;
      4'h1: return !zz;
      4'h2: return cc_;
      4'h3: return !cc_;
      4'h4: return nn;
      4'h5: return !nn;
      4'h6: return vv;
      4'h7: return !vv;
      4'h8: return cc_ && !zz;
      4'h9: return !cc_ || zz;
      4'hA: return nn == vv;
      4'hB: return nn != vv;
      4'hC: return !zz && (nn == vv);
      4'hD: return zz || (nn != vv);
      default: return 1'b1;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("mem_valid", bus.mem_valid, m.valid);
    chk("mem_F", bus.mem_F, m.f);
    chk("mem_store_data", bus.mem_store_data, m.sd);
    chk("mem_br_target", bus.mem_br_target, m.bt);
    chk("mem_rd", bus.mem_rd, m.rd);
    chk("mem_reg_write", bus.mem_reg_write, m.rw);
    chk("mem_mem_read", bus.mem_mem_read, m.mr);
    chk("mem_mem_write", bus.mem_mem_write, m.mw);
    chk("mem_mem_to_reg", bus.mem_mem_to_reg, m.m2r);
    chk("mem_br_taken", bus.mem_br_taken, m.taken);
    chk("flags", flags, m.flags);
`ifdef EX_MEM_PERF_CNT_EN
    chk("perf_br_taken", perf_br_taken, m.pbt);
    chk("perf_flag_wr", perf_flag_wr, m.pfw);
`endif
  endtask
  task automatic step(input logic rs, input logic st, input logic fl);
    st_t x;
    x = m;
    reset = rs;
    stall = st;
    flush = fl;
    if (rs) x = '0;
    else if (!st) begin
      x = '0;
      x.flags = m.flags;
      x.pbt = m.pbt;
      x.pfw = m.pfw;
      if (!fl) begin
        x.valid = bus.ex_valid;
        x.f = bus.ex_F;
        x.sd = bus.ex_store_data;
        x.bt = bus.ex_br_target;
        x.rd = bus.ex_rd;
        x.rw = bus.ex_valid && bus.ex_reg_write;
        x.mr = bus.ex_valid && bus.ex_mem_read;
        x.mw = bus.ex_valid && bus.ex_mem_write;
        x.m2r = bus.ex_valid && bus.ex_mem_to_reg;
        if (!bus.ex_valid) x.taken = 1'b0;
        else if (bus.ex_uncond) x.taken = 1'b1;
        else if (bus.ex_cbz) x.taken = bus.ex_status[1];
        else if (bus.ex_cbnz) x.taken = !bus.ex_status[1];
        else if (bus.ex_bcond) x.taken = cond_hold(bus.ex_cond, m.flags);
        else x.taken = 1'b0;
        if (x.taken) x.pbt = m.pbt + 1;
        if (bus.ex_valid && bus.ex_set_flags) begin
          x.flags = bus.ex_status;
          x.pfw = m.pfw + 1;
        end
      end
    end
    @(posedge clock);
    #1;
    m = x;
    check_all();
  endtask
  task automatic idle();
    bus.ex_valid = 0;
    bus.ex_F = '0;
    bus.ex_status = '0;
    bus.ex_set_flags = 0;
    bus.ex_cbz = 0;
    bus.ex_cbnz = 0;
    bus.ex_bcond = 0;
    bus.ex_uncond = 0;
    bus.ex_cond = '0;
    bus.ex_br_target = '0;
    bus.ex_store_data = '0;
    bus.ex_rd = '0;
    bus.ex_reg_write = 0;
    bus.ex_mem_read = 0;
    bus.ex_mem_write = 0;
    bus.ex_mem_to_reg = 0;
  endtask
  task automatic rand_ex();
    bus.ex_valid = ($urandom_range(0, 9) != 0);
    bus.ex_F = {$urandom, $urandom};
    bus.ex_status = 4'($urandom);
    bus.ex_set_flags = ($urandom_range(0, 2) == 0);
    bus.ex_cbz = ($urandom_range(0, 5) == 0);
    bus.ex_cbnz = ($urandom_range(0, 5) == 0);
    bus.ex_bcond = ($urandom_range(0, 2) == 0);
    bus.ex_uncond = ($urandom_range(0, 7) == 0);
    bus.ex_cond = 4'($urandom);
    bus.ex_br_target = {$urandom, $urandom};
    bus.ex_store_data = {$urandom, $urandom};
    bus.ex_rd = 5'($urandom);
    bus.ex_reg_write = 1'($urandom);
    bus.ex_mem_read = 1'($urandom);
    bus.ex_mem_write = 1'($urandom);
    bus.ex_mem_to_reg = 1'($urandom);
  endtask
  task automatic bcond(input logic [3:0] cc);
    idle();
    bus.ex_valid = 1;
    bus.ex_bcond = 1;
    bus.ex_cond = cc;
    step(0, 0, 0);
  endtask
  initial begin
    idle();
    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_flags", flags, 4'b0000);
    chk("reset_valid", bus.mem_valid, 1'b0);
    step(0, 0, 0);
    chk("idle_valid", bus.mem_valid, 1'b0);
    bus.ex_valid = 1;
    bus.ex_set_flags = 1;
    bus.ex_status = 4'b0010;
    step(0, 0, 0);
    chk("subs_flags", flags, 4'b0010);
    bcond(4'h0);
    chk("beq_taken", bus.mem_br_taken, 1'b1);
    bcond(4'h1);
    chk("bne_taken", bus.mem_br_taken, 1'b0);
    idle();
    bus.ex_valid = 1;
    bus.ex_set_flags = 1;
    bus.ex_status = 4'b1000;
    step(0, 0, 0);
    bcond(4'hB);
    chk("blt_taken", bus.mem_br_taken, 1'b1);
    bcond(4'hA);
    chk("bge_taken", bus.mem_br_taken, 1'b0);
    bcond(4'hC);
    chk("bgt_taken", bus.mem_br_taken, 1'b0);
    idle();
    bus.ex_valid = 1;
    bus.ex_cbz = 1;
    bus.ex_status = 4'b0010;
    step(0, 0, 0);
    chk("cbz_taken", bus.mem_br_taken, 1'b1);
    bus.ex_cbz = 0;
    bus.ex_cbnz = 1;
    step(0, 0, 0);
    chk("cbnz_taken", bus.mem_br_taken, 1'b0);
    chk("cb_flags", flags, 4'b1000);
    idle();
    bus.ex_valid = 1;
    bus.ex_reg_write = 1;
    bus.ex_F = 64'h0123_4567_89AB_CDEF;
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      step(0, 1, 0);
      chk("stall_F", bus.mem_F, 64'h0123_4567_89AB_CDEF);
    end
    idle();
    bus.ex_valid = 1;
    bus.ex_set_flags = 1;
    bus.ex_reg_write = 1;
    bus.ex_status = 4'b1111;
    step(0, 0, 1);
    chk("flush_valid", bus.mem_valid, 1'b0);
    chk("flush_rw", bus.mem_reg_write, 1'b0);
    chk("flush_flags", flags, 4'b1000);
    bus.ex_set_flags = 0;
    step(0, 0, 0);
    bus.ex_valid = 0;
    step(0, 1, 1);
    chk("stall_flush_valid", bus.mem_valid, 1'b1);
    step(1, 1, 1);
    chk("reset_over_stall", bus.mem_valid, 1'b0);
`ifdef EX_MEM_PERF_CNT_EN
    idle();
    bus.ex_valid = 1;
    bus.ex_uncond = 1;
    for (int i = 0; i < 6; i++) begin
      bus.ex_set_flags = (i < 3) || (i == 3);
      step(0, i == 3, 0);
    end
    chk("perf_br5", perf_br_taken, 32'd5);
    chk("perf_fw3", perf_flag_wr, 32'd3);
`endif
    for (int i = 0; i < 600; i++) begin
      rand_ex();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
